// File: rtl/apb_slave_regfile_if.sv
// rtl/apb_slave_regfile_if.sv - APB bus bundle between a requester and the register-file completer
//
// Purpose: groups the shared APB select/enable/address/data lines and the
// completer response lines so they travel as one port.
// Signals:
//   Pselx   [2:0]  one-hot completer select (requester -> completer)
//   Penable        ACCESS phase indicator   (requester -> completer)
//   Pwrite         1 = write, 0 = read      (requester -> completer)
//   Paddr   [31:0] byte address             (requester -> completer)
//   Pwdata  [31:0] write data               (requester -> completer)
//   Prdata  [31:0] read data                (completer -> requester)
//   Pready         transfer completes       (completer -> requester)
//   Pslverr        error response           (completer -> requester)
interface apb_slave_regfile_if;
  logic [2:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;
  logic        Pready;
  logic        Pslverr;

  modport master (
    output Pselx, Penable, Pwrite, Paddr, Pwdata,
    input  Prdata, Pready, Pslverr
  );

  modport slave (
    input  Pselx, Penable, Pwrite, Paddr, Pwdata,
    output Prdata, Pready, Pslverr
  );
endinterface

// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - APB completer with a word-addressed register file
//
// Purpose: answers APB transfers addressed to Pselx[SLV_IDX], holding DEPTH
// 32-bit registers starting at byte address BASE_ADDR. Misaligned or
// out-of-window addresses complete with Pslverr and never write.
// Optional feature: define APB_SLV_WAIT_EN to insert WAIT_CYCLES wait states
// per transfer; without it every transfer completes in 2 cycles.
// Ports:
//   Pclk    clock, rising edge
//   Preset  synchronous active-high reset
//   bus     apb_slave_regfile_if.slave (Pselx, Penable, Pwrite, Paddr,
//           Pwdata in; Prdata, Pready, Pslverr out, all registered)
module apb_slave_regfile #(
  parameter int unsigned SLV_IDX     = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic                Pclk,
  input logic                Preset,
  apb_slave_regfile_if.slave bus
);

  localparam int unsigned IDX_W    = $clog2(DEPTH);
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);

  if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("apb_slave_regfile: DEPTH must be a power of two in 2..256");
  end
  if (SLV_IDX > 2) begin : g_bad_idx
    $error("apb_slave_regfile: SLV_IDX must be 0..2");
  end
  if (WAIT_CYCLES > 15) begin : g_bad_wait
    $error("apb_slave_regfile: WAIT_CYCLES must be 0..15");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t state, state_nxt;

  logic [31:0] mem [DEPTH];

  logic [IDX_W-1:0] idx_q;
  logic             wr_q;
  logic [31:0]      wdata_q;
  logic             err_q;
  logic [31:0]      prdata_q;
  logic             pready_q;
  logic             pslverr_q;

`ifdef APB_SLV_WAIT_EN
  logic [3:0] wait_cnt, wait_cnt_nxt;
`endif

  // Decode of the live bus request, used when latching in setup.
  logic             sel;
  logic [31:0]      offset;
  logic             bus_err;
  logic [IDX_W-1:0] bus_idx;

  assign sel     = bus.Pselx[SLV_IDX];
  assign offset  = bus.Paddr - BASE_ADDR;
  assign bus_err = (bus.Paddr < BASE_ADDR) ||
                   ({1'b0, bus.Paddr} >= END_ADDR) ||
                   (bus.Paddr[1:0] != 2'b00);
  assign bus_idx = offset[IDX_W+1:2];

  // Other select bits and the unused offset bits are deliberately ignored.
  logic unused_bits;
  assign unused_bits = ^{bus.Pselx, offset};

  logic setup;
  logic commit;

  always_comb begin
    state_nxt = state;
    setup     = 1'b0;
    commit    = 1'b0;
`ifdef APB_SLV_WAIT_EN
    wait_cnt_nxt = wait_cnt;
`endif
    case (state)
      ST_IDLE: begin
        // ACCESS without a preceding setup is not a transfer for us.
        if (sel && !bus.Penable) begin
          setup = 1'b1;
`ifdef APB_SLV_WAIT_EN
          if (WAIT_CYCLES > 0) begin
            state_nxt    = ST_WAIT;
            wait_cnt_nxt = 4'(WAIT_CYCLES);
          end else begin
            state_nxt = ST_RESP;
          end
`else
          state_nxt = ST_RESP;
`endif
        end
      end
      ST_WAIT: begin
`ifdef APB_SLV_WAIT_EN
        wait_cnt_nxt = wait_cnt - 4'd1;
        if (wait_cnt == 4'd1) begin
          state_nxt = ST_RESP;
        end
`else
        state_nxt = ST_RESP;
`endif
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
        // Requester dropping sel/Penable here aborts the write.
        commit    = sel && bus.Penable && wr_q && !err_q;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Response values are computed one edge early so the outputs are registered.
  // Entering ST_RESP straight from IDLE uses the live decode, since the
  // latched copy is only written on that same edge.
  logic             rsp_err;
  logic             rsp_wr;
  logic [IDX_W-1:0] rsp_idx;
  logic             enter_resp;
  logic [31:0]      prdata_nxt;

  always_comb begin
    rsp_err    = (state == ST_IDLE) ? bus_err    : err_q;
    rsp_wr     = (state == ST_IDLE) ? bus.Pwrite : wr_q;
    rsp_idx    = (state == ST_IDLE) ? bus_idx    : idx_q;
    enter_resp = (state_nxt == ST_RESP);
    prdata_nxt = 32'h0;
    if (enter_resp && !rsp_wr && !rsp_err) begin
      prdata_nxt = mem[rsp_idx];
    end
  end

  always_ff @(posedge Pclk) begin
    if (Preset) begin
      state     <= ST_IDLE;
      idx_q     <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= 32'h0;
      err_q     <= 1'b0;
      prdata_q  <= 32'h0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
`ifdef APB_SLV_WAIT_EN
      wait_cnt  <= 4'd0;
`endif
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= 32'h0;
      end
    end else begin
      state     <= state_nxt;
      prdata_q  <= prdata_nxt;
      pready_q  <= enter_resp;
      pslverr_q <= enter_resp && rsp_err;
`ifdef APB_SLV_WAIT_EN
      wait_cnt  <= wait_cnt_nxt;
`endif
      if (setup) begin
        idx_q   <= bus_idx;
        wr_q    <= bus.Pwrite;
        wdata_q <= bus.Pwdata;
        err_q   <= bus_err;
      end
      if (commit) begin
        mem[idx_q] <= wdata_q;
      end
    end
  end

  assign bus.Prdata  = prdata_q;
  assign bus.Pready  = pready_q;
  assign bus.Pslverr = pslverr_q;

endmodule

// File: doc/apb_slave_regfile.md
# apb_slave_regfile

APB completer (slave) holding a small word-addressed register file, answering transfers from the APB FSM controller on the shared Pselx/Penable/Paddr bus. Decodes its own select line, sequences SETUP/ACCESS with optional wait states via Pready, and returns read data or a slave error. It is the responder-side counterpart used as a bus endpoint in the bridge testbench and in standalone peripheral integration.

## Interface
- SLV_IDX, 0: bit of Pselx this slave responds to (0..2)
- BASE_ADDR, 32'h0000_0000: byte address of word 0
- DEPTH, 16: number of 32-bit registers (power of two, 2..256)
- WAIT_CYCLES, 2: wait states inserted per transfer (0..15), used only when APB_SLV_WAIT_EN is defined

- Pclk  input  1  clock; all logic on rising edge
- Preset  input  1  synchronous, active-high reset
- Pselx  input  3  one-hot slave select; only bit SLV_IDX is observed
- Penable  input  1  ACCESS phase indicator
- Pwrite  input  1  1 = write, 0 = read
- Paddr  input  32  byte address
- Pwdata  input  32  write data
- Prdata  output  32  read data, valid only while Pready=1 on a read
- Pready  output  1  transfer completes in the cycle it is high
- Pslverr  output  1  error response, valid only while Pready=1

## Operation
- sel = Pselx[SLV_IDX]. All outputs registered.
- States: ST_IDLE, ST_WAIT, ST_RESP.
- ST_IDLE: on sel && !Penable (setup phase) latch Paddr, Pwrite, Pwdata, and the error flag; go ST_WAIT with wait_cnt = WAIT_CYCLES if WAIT_CYCLES>0 (and macro defined), else ST_RESP. sel && Penable seen in IDLE (no setup) is ignored.
- ST_WAIT: wait_cnt decrements each cycle; at wait_cnt==1 go ST_RESP. Pready=0.
- ST_RESP: Pready=1. Leaving ST_RESP always goes to ST_IDLE. Write committed to mem[idx] at the clock edge ending ST_RESP only if sel && Penable && Pwrite_latched && !err. If sel or Penable dropped in ST_RESP (abort), no write, return to IDLE.
- Error: err=1 when Paddr < BASE_ADDR, Paddr >= BASE_ADDR + 4*DEPTH, or Paddr[1:0] != 0. On error Pslverr=1 in ST_RESP, write suppressed, Prdata=0.
- idx = (Paddr - BASE_ADDR) >> 2, width clog2(DEPTH); computed from latched address.
- Read: Prdata loaded with mem[idx] (or 0 on error) on the edge entering ST_RESP; Prdata returns to 0 on the edge leaving ST_RESP. Prdata=0 during writes.
- Pslverr=0 outside ST_RESP.
- Reset: state=ST_IDLE, wait_cnt=0, Pready=0, Pslverr=0, Prdata=0, all mem words=0. Reset mid-transfer abandons it; no write occurs in the reset cycle.

## Timing
- Cycle T0: master setup (sel=1, Penable=0). Edge end of T0: slave latches request.
- N = WAIT_CYCLES (0 without macro). Cycles T1..T(N): Pready=0. Cycle T(N+1): Pready=1, Prdata/Pslverr valid. Transfer length N+2 cycles.
- Write visible to a read whose setup starts in the cycle after ST_RESP.
- Back-to-back: new setup in the cycle after ST_RESP is accepted (IDLE occupied 1 cycle); no bubble beyond the master's.
- Pselx bits other than SLV_IDX never affect state.

## Configuration
- APB_SLV_WAIT_EN defined: WAIT_CYCLES wait states inserted via ST_WAIT and wait_cnt.
- Undefined: ST_WAIT and wait_cnt unreachable/removed; IDLE always goes to ST_RESP; every transfer is 2 cycles, Pready high in the cycle after setup. Controller without Pready support requires this setting.

## Test plan
- No wait (macro off): write 32'hDEAD_BEEF to BASE_ADDR+8, then read BASE_ADDR+8 -> Pready=1 in 2nd cycle of each transfer, Prdata=32'hDEAD_BEEF, Pslverr=0.
- Macro on, WAIT_CYCLES=3: read BASE_ADDR+0 after reset -> Pready low 3 cycles after setup, high in 5th cycle, Prdata=0.
- Out-of-range write Paddr=BASE_ADDR+4*DEPTH, data 32'h1234 -> Pslverr=1 with Pready; subsequent reads of all words return 0.
- Misaligned read Paddr=BASE_ADDR+2 -> Pslverr=1, Prdata=0.
- Pselx selects another slave (bit != SLV_IDX) with write -> Pready stays 0, memory unchanged.
- Preset asserted during ST_WAIT of a write to word 1 -> next cycle all outputs 0, state IDLE; read of word 1 returns 0.
